counter_checker: RTL and testbench

Synthesizable in-line checker sitting directly downstream of the 4-bit counter DUT (counterA/B/C) in the verification environment. It observes the same stimulus the DUT receives plus the DUT's registered outputs, runs a cycle-accurate golden counter model, and flags every cycle where Q, rco or load disagree with the model. It keeps a saturating error count and captures the first mismatch for post-run inspection.

---
 rtl/counter_checker.sv | 168 ++++++++++++++++
 tb/tb_counter_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
// counter_checker: cycle-accurate golden model and scoreboard for the 4-bit counter DUT (rev 1.0).
// Define COUNTER_CHECKER_FIRST_ERR_EN to capture the cycle, expected value and observed value of the first mismatch.
`default_nettype none

module counter_checker #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8,
  parameter int CYC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dut_reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   D,
  input  logic [WIDTH-1:0]   Q,
  input  logic               rco,
  input  logic               load,
  output logic               synced,
  output logic               err_flag,
  output logic [ERR_W-1:0]   err_count,
  output logic [CYC_W-1:0]   check_count,
  output logic [CYC_W-1:0]   first_err_cycle,
  output logic [WIDTH+1:0]   first_err_exp,
  output logic [WIDTH+1:0]   first_err_act
);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    ARM    = 2'd1,
    CHECK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   exp_q_q, exp_q_d;
  logic               exp_rco_q, exp_rco_d;
  logic               exp_load_q, exp_load_d;
  logic               synced_q, synced_d;
  logic               err_flag_q, err_flag_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [CYC_W-1:0]   check_count_q, check_count_d;
  logic [WIDTH+1:0]   exp_vec, act_vec;
  logic               do_check, mismatch;

  assign exp_vec  = {exp_load_q, exp_rco_q, exp_q_q};
  assign act_vec  = {load, rco, Q};
  assign do_check = (state_q == CHECK);
  // Case inequality so X/Z on the DUT outputs is reported as a mismatch in simulation.
  assign mismatch = (act_vec !== exp_vec);

  always_comb begin
    exp_q_d    = exp_q_q;
    exp_rco_d  = 1'b0;
    exp_load_d = 1'b0;
    if (dut_reset) begin
      exp_q_d = '0;
    end else if (enable) begin
      case (mode)
        2'b00: begin
          exp_q_d   = exp_q_q + WIDTH'(1);
          exp_rco_d = &exp_q_q;
        end
        2'b01: begin
          exp_q_d   = exp_q_q - WIDTH'(1);
          exp_rco_d = ~|exp_q_q;
        end
        2'b10: begin
          exp_q_d   = exp_q_q - WIDTH'(3);
          exp_rco_d = (exp_q_q < WIDTH'(3));
        end
        default: begin
          exp_q_d    = D;
          exp_load_d = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNSYNC:  if (dut_reset) state_d = ARM;
      ARM:     state_d = CHECK;
      CHECK:   state_d = CHECK;
      default: state_d = UNSYNC;
    endcase
    synced_d = (state_d != UNSYNC);

    check_count_d = check_count_q;
    err_count_d   = err_count_q;
    err_flag_d    = err_flag_q;
    if (do_check) begin
      if (~&check_count_q) check_count_d = check_count_q + CYC_W'(1);
      if (mismatch) begin
        err_flag_d = 1'b1;
        if (~&err_count_q) err_count_d = err_count_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= UNSYNC;
      exp_q_q       <= '0;
      exp_rco_q     <= 1'b0;
      exp_load_q    <= 1'b0;
      synced_q      <= 1'b0;
      err_flag_q    <= 1'b0;
      err_count_q   <= '0;
      check_count_q <= '0;
    end else begin
      state_q       <= state_d;
      exp_q_q       <= exp_q_d;
      exp_rco_q     <= exp_rco_d;
      exp_load_q    <= exp_load_d;
      synced_q      <= synced_d;
      err_flag_q    <= err_flag_d;
      err_count_q   <= err_count_d;
      check_count_q <= check_count_d;
    end
  end

  assign synced      = synced_q;
  assign err_flag    = err_flag_q;
  assign err_count   = err_count_q;
  assign check_count = check_count_q;

`ifdef COUNTER_CHECKER_FIRST_ERR_EN
  logic [CYC_W-1:0] first_err_cycle_q, first_err_cycle_d;
  logic [WIDTH+1:0] first_err_exp_q, first_err_exp_d;
  logic [WIDTH+1:0] first_err_act_q, first_err_act_d;

  // The cycle stamp is the comparison index, i.e. check_count before this comparison.
  always_comb begin
    first_err_cycle_d = first_err_cycle_q;
    first_err_exp_d   = first_err_exp_q;
    first_err_act_d   = first_err_act_q;
    if (do_check && mismatch && !err_flag_q) begin
      first_err_cycle_d = check_count_q;
      first_err_exp_d   = exp_vec;
      first_err_act_d   = act_vec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_err_cycle_q <= '0;
      first_err_exp_q   <= '0;
      first_err_act_q   <= '0;
    end else begin
      first_err_cycle_q <= first_err_cycle_d;
      first_err_exp_q   <= first_err_exp_d;
      first_err_act_q   <= first_err_act_d;
    end
  end

  assign first_err_cycle = first_err_cycle_q;
  assign first_err_exp   = first_err_exp_q;
  assign first_err_act   = first_err_act_q;
`else
  assign first_err_cycle = '0;
  assign first_err_exp   = '0;
  assign first_err_act   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_checker.sv
// tb_counter_checker: directed scoreboard bench for counter_checker; the bench plays the counter DUT
// and injects corrupted outputs on chosen cycles.
`default_nettype none

module tb_counter_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dut_reset = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  D = 4'h0;
  logic [3:0]  Q = 4'h0;
  logic        rco = 1'b0;
  logic        load = 1'b0;
  logic        synced, err_flag;
  logic [7:0]  err_count;
  logic [15:0] check_count, first_err_cycle;
  logic [5:0]  first_err_exp, first_err_act;

  counter_checker #(.WIDTH(4), .ERR_W(8), .CYC_W(16)) dut (
    .clk(clk), .reset(reset), .dut_reset(dut_reset), .enable(enable), .mode(mode), .D(D),
    .Q(Q), .rco(rco), .load(load), .synced(synced), .err_flag(err_flag),
    .err_count(err_count), .check_count(check_count), .first_err_cycle(first_err_cycle),
    .first_err_exp(first_err_exp), .first_err_act(first_err_act)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        f;
    logic [7:0]  ec;
    logic [15:0] cc;
    logic [15:0] fc;
    logic [5:0]  fe;
    logic [5:0]  fa;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Bench-side DUT counter registers and checker reference state.
  int          g_q = 0;
  logic        g_rco = 1'b0, g_load = 1'b0;
  int          m_state = 0;   // 0 unsynced, 1 armed, 2 checking
  int          m_cc = 0, m_ec = 0;
  logic        m_flag = 1'b0;
  logic [15:0] m_fc = '0;
  logic [5:0]  m_fe = '0, m_fa = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    g_q = 0; g_rco = 1'b0; g_load = 1'b0;
    m_state = 0; m_cc = 0; m_ec = 0; m_flag = 1'b0;
    m_fc = '0; m_fe = '0; m_fa = '0;
    sb.delete();
  endtask

  // One clock: drive stimulus plus (optionally corrupted) DUT outputs, predict, then compare.
  task automatic step(input logic r, input logic en, input logic [1:0] md, input logic [3:0] d,
                      input logic [5:0] corrupt);
    exp_t e;
    logic [5:0] good;
    int nq;
    @(negedge clk);
    good = {g_load, g_rco, 4'(g_q)};
    dut_reset = r; enable = en; mode = md; D = d;
    {load, rco, Q} = good ^ corrupt;
    if (m_state == 2) begin
      if (corrupt != 6'h00 && !m_flag) begin
        m_fc = 16'(m_cc); m_fe = good; m_fa = good ^ corrupt;
      end
      if (m_cc < 65535) m_cc = m_cc + 1;
      if (corrupt != 6'h00) begin
        m_flag = 1'b1;
        if (m_ec < 255) m_ec = m_ec + 1;
      end
    end
    if (m_state == 0) m_state = r ? 1 : 0;
    else m_state = 2;
    nq = g_q; g_rco = 1'b0; g_load = 1'b0;
    if (r) nq = 0;
    else if (en) begin
      if (md == 2'b00) begin nq = (g_q + 1) % 16; g_rco = (g_q == 15); end
      else if (md == 2'b01) begin nq = (g_q + 15) % 16; g_rco = (g_q == 0); end
      else if (md == 2'b10) begin nq = (g_q + 13) % 16; g_rco = (g_q < 3); end
      else begin nq = int'(d); g_load = 1'b1; end
    end
    g_q = nq;
    e.s = (m_state != 0); e.f = m_flag; e.ec = 8'(m_ec); e.cc = 16'(m_cc);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    e.fc = m_fc; e.fe = m_fe; e.fa = m_fa;
`else
    e.fc = '0; e.fe = '0; e.fa = '0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("synced", 32'(synced), 32'(e.s));
    chk("err_flag", 32'(err_flag), 32'(e.f));
    chk("err_count", 32'(err_count), 32'(e.ec));
    chk("check_count", 32'(check_count), 32'(e.cc));
    chk("first_err_cycle", 32'(first_err_cycle), 32'(e.fc));
    chk("first_err_exp", 32'(first_err_exp), 32'(e.fe));
    chk("first_err_act", 32'(first_err_act), 32'(e.fa));
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_synced", 32'(synced), 32'h0);
    chk("rst_err_flag", 32'(err_flag), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    chk("rst_check_count", 32'(check_count), 32'h0);
    chk("rst_first_err_cycle", 32'(first_err_cycle), 32'h0);
    chk("rst_first_err_exp", 32'(first_err_exp), 32'h0);
    chk("rst_first_err_act", 32'(first_err_act), 32'h0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_clear();
    #1;
    chk("por_synced", 32'(synced), 32'h0);
    chk("por_err_count", 32'(err_count), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // No dut_reset pulse yet: wrong outputs must not be scored.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'b00, 4'h0, 6'h05);
    chk("unsync_count", 32'(check_count), 32'h0);

    // Sync, then 20 up-counts including the 15->0 carry.
    step(1'b1, 1'b0, 2'b00, 4'h0, 6'h00);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 2'b00, 4'h0, 6'h00);
    step(1'b0, 1'b0, 2'b00, 4'h0, 6'h00);
    chk("up20_checks", 32'(check_count), 32'd20);
    chk("up20_errors", 32'(err_count), 32'd0);

    // Down-by-3 from 1 borrows to 14; DUT reports 15 instead.
    step(1'b1, 1'b0, 2'b00, 4'h0, 6'h00);
    step(1'b0, 1'b1, 2'b00, 4'h0, 6'h00);
    step(1'b0, 1'b1, 2'b10, 4'h0, 6'h00);
    step(1'b0, 1'b0, 2'b10, 4'h0, 6'h01);
    chk("sub3_err_count", 32'(err_count), 32'd1);
    chk("sub3_err_flag", 32'(err_flag), 32'd1);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    chk("sub3_first_exp", 32'(first_err_exp), 32'h1E);
    chk("sub3_first_act", 32'(first_err_act), 32'h1F);
`else
    chk("sub3_first_exp", 32'(first_err_exp), 32'h0);
    chk("sub3_first_act", 32'(first_err_act), 32'h0);
`endif

    // Load of A with the DUT missing its load indicator.
    step(1'b0, 1'b1, 2'b11, 4'hA, 6'h00);
    step(1'b0, 1'b1, 2'b01, 4'h3, 6'h20);
    chk("load_err_count", 32'(err_count), 32'd2);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'(i % 4), 4'(i * 3), 6'h00);
    chk("mixed_err_count", 32'(err_count), 32'd2);

    // Persistent mismatch drives the error counter into saturation.
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 2'b01, 4'h0, 6'h01);
    chk("sat_err_count", 32'(err_count), 32'd255);
    chk("sat_err_flag", 32'(err_flag), 32'd1);

    // Mid-run asynchronous reset, then unscored cycles until a new dut_reset.
    async_reset_check();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b00, 4'h0, 6'h3F);
    chk("resync_wait", 32'(err_count), 32'd0);
    step(1'b1, 1'b1, 2'b00, 4'h0, 6'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'b01, 4'h0, 6'h00);
    step(1'b0, 1'b1, 2'b01, 4'h0, 6'h02);
    chk("resync_err_count", 32'(err_count), 32'd1);
    chk("resync_check_count", 32'(check_count), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
